// File: rtl/cpu_run_ctrl_if.sv
// Run-control bundle between the CPU harness and cpu_run_ctrl: PC sampling and
// stop request in, core reset and run status out.
interface cpu_run_ctrl_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic [PC_W-1:0]  pc;
    logic             pc_valid;
    logic             halt_req;
    logic             core_reset;
    logic             running;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output pc, pc_valid, halt_req,
        input  core_reset, running, done, timeout, cycle_cnt
    );

    modport slave (
        input  pc, pc_valid, halt_req,
        output core_reset, running, done, timeout, cycle_cnt
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Holds a CPU in reset, lets it run, and stops it on a halt request, a stuck PC
// or an exhausted cycle budget.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_HOLD    | core_reset asserted for RST_CYCLES clocks after reset
//   ST_RUN     | core released, cycle budget and PC repeat tracking active
//   ST_DONE    | halted (request or stuck PC); core frozen until reset
//   ST_TIMEOUT | budget exhausted; core frozen until reset
module cpu_run_ctrl #(
    parameter int RST_CYCLES  = 5,
    parameter int MAX_CYCLES  = 10000,
    parameter int HALT_REPEAT = 4,
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32
) (
    input  logic          clk,
    input  logic          reset,
    cpu_run_ctrl_if.slave bus
);
    localparam int HOLD_W = $clog2(RST_CYCLES + 1);
    localparam int REP_W  = $clog2(HALT_REPEAT + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_TGT   = REP_W'(HALT_REPEAT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_CYCLES);

    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic [PC_W-1:0]   last_pc_q, last_pc_d;
    logic              pc_seen_q, pc_seen_d;
    logic              core_reset_q, core_reset_d;
    logic              running_q, running_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              halt;
    logic              budget_out;

    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        last_pc_d   = last_pc_q;
        pc_seen_d   = pc_seen_q;
        halt        = 1'b0;
        budget_out  = 1'b0;

        case (state_q)
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cycle_cnt_q != CNT_MAX) begin
                    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                end
                budget_out = (cycle_cnt_d == CNT_MAX);

                // The first valid sample only primes last_pc.
                if (bus.pc_valid) begin
                    last_pc_d = bus.pc;
                    pc_seen_d = 1'b1;
                    if (pc_seen_q) begin
                        rep_cnt_d = (bus.pc == last_pc_q) ? rep_cnt_q + REP_W'(1) : '0;
                    end
                end

                halt = bus.halt_req || (rep_cnt_d == REP_TGT);
                if (halt) begin
                    state_d = ST_DONE;
                end else if (budget_out) begin
                    state_d = ST_TIMEOUT;
                end
            end
            default: begin
            end
        endcase

        core_reset_d = (state_d != ST_RUN);
        running_d    = (state_d == ST_RUN);
        done_d       = (state_d == ST_DONE);
        timeout_d    = (state_d == ST_TIMEOUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= '0;
            cycle_cnt_q  <= '0;
            rep_cnt_q    <= '0;
            last_pc_q    <= '0;
            pc_seen_q    <= 1'b0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            rep_cnt_q    <= rep_cnt_d;
            last_pc_q    <= last_pc_d;
            pc_seen_q    <= pc_seen_d;
            core_reset_q <= core_reset_d;
            running_q    <= running_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.core_reset = core_reset_q;
    assign bus.running    = running_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.cycle_cnt  = cycle_cnt_q;
endmodule
